// File: rtl/fixed_accum.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_accum
//  Purpose  : Streaming fixed-point accumulator. Sums ACC_LEN accepted samples
//             in full precision, then rounds/saturates the total into the
//             (N_BITS_OUT,BIN_PT_OUT) format behind a one-entry valid/ready
//             output register.
//  Ports    : clk, rst_n (async active-low), clr (sync clear)
//             in_data/in_valid/in_ready    : sample stream (input side)
//             out_data/out_valid/out_ready : result stream (output side)
//             out_sat                      : result was clipped (with out_valid)
//  Revision : 1.0  initial release
// ============================================================================
module fixed_accum #(
    parameter int N_BITS_IN  = 6,
    parameter int BIN_PT_IN  = 3,
    parameter int SIGNED_IN  = 1,
    parameter int ACC_LEN    = 4,
    parameter int N_BITS_OUT = 8,
    parameter int BIN_PT_OUT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [N_BITS_IN-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_BITS_OUT-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sat
);

    localparam int W_ACC = N_BITS_IN + $clog2(ACC_LEN);
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int LSH   = (BIN_PT_OUT >= BIN_PT_IN) ? (BIN_PT_OUT - BIN_PT_IN) : 0;
    localparam int RSH   = (BIN_PT_IN > BIN_PT_OUT) ? (BIN_PT_IN - BIN_PT_OUT) : 0;
    // Working width: holds the aligned total, the output range limits, a guard
    // bit for the rounding add and a sign bit.
    localparam int W_WK  = (((W_ACC + LSH) > N_BITS_OUT) ? (W_ACC + LSH) : N_BITS_OUT) + 2;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(ACC_LEN - 1);
    localparam logic signed [W_WK-1:0] c_max = (SIGNED_IN != 0)
        ? ((W_WK'(1) << (N_BITS_OUT - 1)) - W_WK'(1))
        : ((W_WK'(1) << N_BITS_OUT) - W_WK'(1));
    localparam logic signed [W_WK-1:0] c_min = (SIGNED_IN != 0)
        ? -(W_WK'(1) << (N_BITS_OUT - 1))
        : W_WK'(0);

    logic [W_ACC-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [N_BITS_OUT-1:0] out_data_q, out_data_d;
    logic                  out_sat_q, out_sat_d;

    logic [W_ACC-1:0]       w_sample;
    logic [W_ACC-1:0]       w_total;
    logic signed [W_WK-1:0] w_ext;
    logic signed [W_WK-1:0] w_aligned;
    logic [N_BITS_OUT-1:0]  w_conv;
    logic                   w_conv_sat;
    logic                   w_accept;
    logic                   w_final;

    // Extension of the sample and of the block total follows the input format.
    if (SIGNED_IN != 0) begin : g_signed
        assign w_sample = W_ACC'($signed(in_data));
        assign w_ext    = W_WK'($signed(w_total));
    end else begin : g_unsigned
        assign w_sample = W_ACC'(in_data);
        assign w_ext    = $signed(W_WK'(w_total));
    end

    assign w_total = acc_q + w_sample;

    if (BIN_PT_OUT >= BIN_PT_IN) begin : g_shl
        assign w_aligned = w_ext <<< LSH;
    end else begin : g_shr
        // Add half an output LSB then floor: round half toward +inf.
        localparam logic signed [W_WK-1:0] c_half = W_WK'(1) << (RSH - 1);
        assign w_aligned = (w_ext + c_half) >>> RSH;
    end

    always_comb begin
        w_conv     = w_aligned[N_BITS_OUT-1:0];
        w_conv_sat = 1'b0;
        if (w_aligned > c_max) begin
            w_conv     = c_max[N_BITS_OUT-1:0];
            w_conv_sat = 1'b1;
        end else if (w_aligned < c_min) begin
            w_conv     = c_min[N_BITS_OUT-1:0];
            w_conv_sat = 1'b1;
        end
    end

    // A pending result blocks input unless it drains this very cycle.
    assign in_ready = ~out_valid_q | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_final  = w_accept & (cnt_q == c_last);

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (w_final) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (w_accept) begin
            acc_d = w_total;
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (w_final) begin
            out_valid_d = 1'b1;
            out_data_d  = w_conv;
            out_sat_d   = w_conv_sat;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear wins over any accept in the same cycle.
        if (clr) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fixed_accum
//  Purpose  : Directed self-checking bench for fixed_accum. Three instances
//             share one input stream: default format, a narrow saturating
//             output, and a single-sample rounding configuration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fixed_accum;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [5:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_sat;
    logic [7:0] a_out_data;
    logic       s_in_ready, s_out_valid, s_out_sat;
    logic [4:0] s_out_data;
    logic       l_in_ready, l_out_valid, l_out_sat;
    logic [5:0] l_out_data;

    int n_vec = 0;
    int n_err = 0;

    fixed_accum u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sat(a_out_sat)
    );

    fixed_accum #(.ACC_LEN(4), .N_BITS_OUT(5), .BIN_PT_OUT(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sat(s_out_sat)
    );

    fixed_accum #(.ACC_LEN(1), .N_BITS_OUT(6), .BIN_PT_OUT(1)) u_len1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(l_in_ready),
        .out_data(l_out_data), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_sat(l_out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(a_out_valid), 32'h0);
        check("rst_data",  32'(a_out_data),  32'h0);
        check("rst_sat",   32'(a_out_sat),   32'h0);
        check("rst_ready", 32'(a_in_ready),  32'h1);

        // 1: reset mid-block loses the partial sum; 4 x 1/8 -> 1/2
        in_data = 6'd5; in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("t1_rst_valid", 32'(a_out_valid), 32'h0);
        #2 rst_n = 1'b1;
        in_data = 6'b000001; in_valid = 1'b1;
        repeat (3) tick();
        check("t1_latency", 32'(a_out_valid), 32'h0);
        tick();
        check("t1_valid", 32'(a_out_valid), 32'h1);
        check("t1_data",  32'(a_out_data),  32'h04);
        check("t1_sat",   32'(a_out_sat),   32'h0);
        in_valid = 1'b0;
        tick();
        check("t1_drain", 32'(a_out_valid), 32'h0);

        // 2: 4 x -3/8 -> -3/2
        in_data = 6'b111101; in_valid = 1'b1;
        repeat (4) tick();
        check("t2_valid", 32'(a_out_valid), 32'h1);
        check("t2_data",  32'(a_out_data),  32'hF4);
        check("t2_sat",   32'(a_out_sat),   32'h0);
        in_valid = 1'b0;
        tick();

        // 4: backpressure holds the result and blocks input
        out_ready = 1'b0;
        in_data = 6'd2; in_valid = 1'b1;
        repeat (4) tick();
        check("t4_valid", 32'(a_out_valid), 32'h1);
        check("t4_data",  32'(a_out_data),  32'h08);
        in_data = 6'd1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_ready", 32'(a_in_ready), 32'h0);
            check("t4_stall_data",  32'(a_out_data), 32'h08);
            tick();
        end
        check("t4_stall_valid", 32'(a_out_valid), 32'h1);
        out_ready = 1'b1;
        #1 check("t4_ready_back", 32'(a_in_ready), 32'h1);
        tick();
        check("t4_drained", 32'(a_out_valid), 32'h0);
        repeat (3) tick();
        check("t4_next_valid", 32'(a_out_valid), 32'h1);
        check("t4_next_data",  32'(a_out_data),  32'h04);
        in_valid = 1'b0;
        tick();

        // 6: clr discards the partial sum and its own cycle's sample
        in_data = 6'd7; in_valid = 1'b1;
        tick(); tick();
        clr = 1'b1;
        #1 check("t6_clr_ready", 32'(a_in_ready), 32'h1);
        tick();
        clr = 1'b0;
        in_data = 6'b000001;
        repeat (3) tick();
        check("t6_no_early", 32'(a_out_valid), 32'h0);
        tick();
        check("t6_valid", 32'(a_out_valid), 32'h1);
        check("t6_data",  32'(a_out_data),  32'h04);
        out_ready = 1'b0; in_valid = 1'b0;
        tick();
        check("t6_held", 32'(a_out_valid), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_clr_out_valid", 32'(a_out_valid), 32'h0);
        check("t6_clr_out_sat",   32'(a_out_sat),   32'h0);
        out_ready = 1'b1;

        // 3: saturation on the 5-bit output, range limits on the 8-bit one
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_data = 6'b011111; in_valid = 1'b1;
        repeat (4) tick();
        check("t3_pos_data", 32'(s_out_data), 32'h0F);
        check("t3_pos_sat",  32'(s_out_sat),  32'h1);
        check("t3_pos_wide", 32'(a_out_data), 32'h7C);
        check("t3_pos_wsat", 32'(a_out_sat),  32'h0);
        in_data = 6'b100000;
        repeat (4) tick();
        check("t3_neg_data", 32'(s_out_data), 32'h10);
        check("t3_neg_sat",  32'(s_out_sat),  32'h1);
        check("t3_neg_wide", 32'(a_out_data), 32'h80);
        check("t3_neg_wsat", 32'(a_out_sat),  32'h0);
        in_valid = 1'b0;
        tick();

        // 5: ACC_LEN=1, round 3 fractional bits down to 1
        in_valid = 1'b1;
        in_data = 6'b000011; tick();
        check("t5_a", 32'(l_out_data), 32'h01);
        in_data = 6'b000001; tick();
        check("t5_b", 32'(l_out_data), 32'h00);
        check("t5_b_valid", 32'(l_out_valid), 32'h1);
        in_data = 6'b111110; tick();
        check("t5_c", 32'(l_out_data), 32'h00);
        in_data = 6'b111101; tick();
        check("t5_d", 32'(l_out_data), 32'h3F);
        check("t5_d_sat", 32'(l_out_sat), 32'h0);
        in_valid = 1'b0;
        tick();
        check("t5_drain", 32'(l_out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
